// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: conflict-resolution encodings and lockout counter sizing for the SR latch bank
package sr_bank_pkg;

    localparam int PRIO_RESET  = 0;
    localparam int PRIO_SET    = 1;
    localparam int PRIO_HOLD   = 2;
    localparam int PRIO_TOGGLE = 3;

    function automatic int lockout_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sr_channel.sv
// sr_channel: one set/reset storage element with conflict resolution, minimum-off lockout and event flags
module sr_channel
    import sr_bank_pkg::*;
#(
    parameter int PRIORITY       = PRIO_RESET,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    input  logic set,
    input  logic reset,
    output logic q,
    output logic locked,
    output logic changed,
    output logic conflict
);

    localparam int CNT_W = lockout_w(LOCKOUT_CYCLES);

    logic             q_q, q_d;
    logic             changed_q, changed_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             both, blocked, resolved;

    always_comb begin
        both       = set & reset;
        // the counter reaches zero on the edge where it reads 1, so q stays low exactly LOCKOUT_CYCLES cycles
        blocked    = (LOCKOUT_CYCLES != 0) && (cnt_q > CNT_W'(1));
        resolved   = (PRIORITY == PRIO_RESET) ? 1'b0 :
                     (PRIORITY == PRIO_SET)   ? !blocked :
                     (PRIORITY == PRIO_HOLD)  ? q_q : (!q_q && !blocked);
        q_d        = clear ? 1'b0 : !en ? q_q : both ? resolved : reset ? 1'b0 : set ? (q_q | !blocked) : q_q;
        cnt_d      = (LOCKOUT_CYCLES == 0) ? '0 :
                     (q_q && !q_d) ? CNT_W'(LOCKOUT_CYCLES) :
                     (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        changed_d  = q_d != q_q;
        conflict_d = en & both;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= 1'b0;
            cnt_q      <= '0;
            changed_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign locked   = cnt_q != '0;
    assign changed  = changed_q;
    assign conflict = conflict_q;

endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: CHANNELS independent clocked SR channels sharing enable and synchronous clear
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int PRIORITY       = PRIO_RESET,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clear,
    input  logic [CHANNELS-1:0] set,
    input  logic [CHANNELS-1:0] reset,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] locked,
    output logic [CHANNELS-1:0] changed,
    output logic [CHANNELS-1:0] conflict
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sr_channel #(
            .PRIORITY      (PRIORITY),
            .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .clear   (clear),
            .set     (set[i]),
            .reset   (reset[i]),
            .q       (q[i]),
            .locked  (locked[i]),
            .changed (changed[i]),
            .conflict(conflict[i])
        );
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// tb_sr_latch_bank: five banks (modes 0-3 with lockout 8, mode 0 without lockout) against a fall-time reference model
module tb_sr_latch_bank;

    localparam int N = 5;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, clear = 1'b0;
    logic [3:0] set = '0, reset = '0;
    logic [3:0] q_o[N], locked_o[N], changed_o[N], conflict_o[N];

    bit         mq[N][4];
    int         mfall[N][4];
    logic [3:0] mchg[N], mcon[N];
    int         cyc = 0, tests = 0, fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sr_latch_bank #(
            .CHANNELS      (4),
            .PRIORITY      (g < 4 ? g : 0),
            .LOCKOUT_CYCLES(g < 4 ? 8 : 0)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .clear   (clear),
            .set     (set),
            .reset   (reset),
            .q       (q_o[g]),
            .locked  (locked_o[g]),
            .changed (changed_o[g]),
            .conflict(conflict_o[g])
        );
    end

    function automatic int mode(input int g);
        return g < 4 ? g : 0;
    endfunction

    function automatic int lk(input int g);
        return g < 4 ? 8 : 0;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            mchg[g] = '0;
            mcon[g] = '0;
            for (int c = 0; c < 4; c++) begin
                mq[g][c]    = 1'b0;
                mfall[g][c] = -1;
            end
        end
    endtask

    // A set may raise q only once LOCKOUT cycles have elapsed since the last fall.
    task automatic model_edge();
        bit s, r, ok, cur, nq;
        cyc++;
        for (int g = 0; g < N; g++) begin
            for (int c = 0; c < 4; c++) begin
                s   = set[c];
                r   = reset[c];
                cur = mq[g][c];
                ok  = (mfall[g][c] < 0) || (cyc - mfall[g][c] >= lk(g));
                if (clear) nq = 1'b0;
                else if (!en) nq = cur;
                else if (s && r) begin
                    case (mode(g))
                        0:       nq = 1'b0;
                        1:       nq = ok;
                        2:       nq = cur;
                        default: nq = cur ? 1'b0 : ok;
                    endcase
                end
                else if (r) nq = 1'b0;
                else if (s) nq = cur | ok;
                else nq = cur;
                mchg[g][c] = nq != cur;
                mcon[g][c] = en && s && r;
                if (cur && !nq) mfall[g][c] = cyc;
                mq[g][c] = nq;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] eq, el;
        for (int g = 0; g < N; g++) begin
            for (int c = 0; c < 4; c++) begin
                eq[c] = mq[g][c];
                el[c] = (mfall[g][c] >= 0) && (cyc - mfall[g][c] < lk(g));
            end
            chk($sformatf("u%0d.q", g), q_o[g], eq);
            chk($sformatf("u%0d.locked", g), locked_o[g], el);
            chk($sformatf("u%0d.changed", g), changed_o[g], mchg[g]);
            chk($sformatf("u%0d.conflict", g), conflict_o[g], mcon[g]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1 check_all();
    endtask

    task automatic drive(input logic e, input logic cl, input logic [3:0] s, input logic [3:0] r);
        en    = e;
        clear = cl;
        set   = s;
        reset = r;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive(1, 0, 4'b0001, 4'b0000); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        drive(1, 0, 4'b0000, 4'b0001); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        drive(1, 0, 4'b0010, 4'b0000); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        drive(1, 0, 4'b0010, 4'b0010); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        drive(1, 0, 4'b0100, 4'b0000); tick();
        drive(1, 0, 4'b0000, 4'b0100); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 4'b0100, (i == 3) ? 4'b0100 : 4'b0000);
            tick();
        end
        drive(1, 0, 4'b0000, 4'b0000); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 4'b1011, 4'b0000);
            tick();
        end
        drive(1, 1, 4'b0000, 4'b0000); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 4'b0101, 4'b0000);
            tick();
        end
        drive(0, 0, 4'b1111, 4'b0000); tick();
        drive(0, 0, 4'b1111, 4'b1111); tick();
        drive(0, 0, 4'b0000, 4'b1111); tick();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
                  4'($urandom), 4'($urandom) & 4'($urandom));
            tick();
        end
        drive(1, 0, 4'b0001, 4'b0000);
        for (int i = 0; i < 10; i++) tick();
        drive(1, 0, 4'b0000, 4'b0001); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        tick();
        tick();
        rst_n = 1'b1;
        drive(1, 0, 4'b0001, 4'b0000); tick();
        drive(1, 0, 4'b0000, 4'b0000); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
